axi4_default_slave: RTL



---
 rtl/axi4_default_slave_pkg.sv | 9 +
 rtl/axi4_default_slave_if.sv | 28 ++
 rtl/axi4_default_slave_rd.sv | 52 +++++
 rtl/axi4_default_slave.sv | 61 ++++++
 4 files changed

// File: rtl/axi4_default_slave_pkg.sv
// axi4_default_slave_pkg: response encodings and FSM states for the default slave.
package axi4_default_slave_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/axi4_default_slave_if.sv
// axi4_default_slave_if: AXI4 handshake subset seen by the default slave (no address fields).
interface axi4_default_slave_if #(
    parameter int ID_W = 4,
    parameter int DATA_W = 32
);
    logic awvalid, awready;
    logic [ID_W-1:0] awid;
    logic wvalid, wready, wlast;
    logic [DATA_W-1:0] wdata;
    logic bvalid, bready;
    logic [ID_W-1:0] bid;
    logic [1:0] bresp;
    logic arvalid, arready;
    logic [ID_W-1:0] arid;
    logic [7:0] arlen;
    logic rvalid, rready, rlast;
    logic [ID_W-1:0] rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0] rresp;
    modport slave (
        input awvalid, awid, wvalid, wdata, wlast, bready, arvalid, arid, arlen, rready,
        output awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast
    );
    modport master (
        output awvalid, awid, wvalid, wdata, wlast, bready, arvalid, arid, arlen, rready,
        input awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/axi4_default_slave_rd.sv
// axi4_default_slave_rd: read path; answers each AR burst with arlen+1 DECERR beats.
module axi4_default_slave_rd
    import axi4_default_slave_pkg::*;
#(
    parameter int ID_W = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arvalid,
    input  logic [ID_W-1:0]   arid,
    input  logic [7:0]        arlen,
    input  logic              rready,
    output logic              arready,
    output logic              rvalid,
    output logic              rlast,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic [CNT_W-1:0]  rd_err_cnt
);
    r_state_t r_state, r_next;
    logic [7:0] beats;
    logic done;
    assign done = rvalid && rready && beats == 8'd0;
    always_ff @(posedge clk) r_state <= rst ? R_IDLE : r_next;
    always_comb begin
        r_next = r_state == R_IDLE ? (arvalid ? R_DATA : R_IDLE) : (done ? R_IDLE : R_DATA);
    end
    always_comb begin
        arready = r_state == R_IDLE;
        rvalid  = r_state == R_DATA;
        rlast   = r_state == R_DATA && beats == 8'd0;
        rdata   = '0;
        rresp   = RESP_DECERR;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rid        <= '0;
            beats      <= '0;
            rd_err_cnt <= '0;
        end else begin
            if (arvalid && arready) begin
                rid   <= arid;
                beats <= arlen;
            end
            if (rvalid && rready && beats != 8'd0) beats <= beats - 8'd1;
            if (done) rd_err_cnt <= rd_err_cnt + CNT_W'(~&rd_err_cnt);
        end
    end
endmodule

// File: rtl/axi4_default_slave.sv
// axi4_default_slave: terminating AXI4 responder; every AW/W and AR burst is answered with DECERR.
module axi4_default_slave
    import axi4_default_slave_pkg::*;
#(
    parameter int ID_W = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    axi4_default_slave_if.slave bus,
    output logic [CNT_W-1:0]    wr_err_cnt,
    output logic [CNT_W-1:0]    rd_err_cnt
);
    w_state_t w_state, w_next;
    logic [ID_W-1:0] bid_q;
    logic unused_wdata;
    assign unused_wdata = ^bus.wdata;
    always_ff @(posedge clk) w_state <= rst ? W_IDLE : w_next;
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (bus.awvalid) w_next = W_DATA;
            W_DATA:  if (bus.wvalid && bus.wlast) w_next = W_RESP;
            W_RESP:  if (bus.bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end
    // W beats arriving before AW stall here because wready is low in W_IDLE
    always_comb begin
        bus.awready = w_state == W_IDLE;
        bus.wready  = w_state == W_DATA;
        bus.bvalid  = w_state == W_RESP;
        bus.bresp   = RESP_DECERR;
        bus.bid     = bid_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bid_q      <= '0;
            wr_err_cnt <= '0;
        end else begin
            if (bus.awvalid && bus.awready) bid_q <= bus.awid;
            if (bus.bvalid && bus.bready) wr_err_cnt <= wr_err_cnt + CNT_W'(~&wr_err_cnt);
        end
    end
    axi4_default_slave_rd #(.ID_W(ID_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_rd (
        .clk(clk),
        .rst(rst),
        .arvalid(bus.arvalid),
        .arid(bus.arid),
        .arlen(bus.arlen),
        .rready(bus.rready),
        .arready(bus.arready),
        .rvalid(bus.rvalid),
        .rlast(bus.rlast),
        .rid(bus.rid),
        .rdata(bus.rdata),
        .rresp(bus.rresp),
        .rd_err_cnt(rd_err_cnt)
    );
endmodule
